// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-step multiply/divide unit holding the result in HI/LO
module mul_div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] RS_data_i,
  input  logic [31:0] RT_data_i,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic        is_div, sign_n, sign_q, accept, sgn;
  logic [31:0] m, rs, rs_mag, rt_mag, div_r, quo, rem, hi_fix, lo_fix;
  logic [63:0] acc, acc_step, prod;
  logic [32:0] mul_sum, div_p;
  logic [4:0]  cnt;
  logic        div_ge;
  assign sgn    = ~op_i[0];
  assign rs_mag = (sgn && RS_data_i[31]) ? -RS_data_i : RS_data_i;
  assign rt_mag = (sgn && RT_data_i[31]) ? -RT_data_i : RT_data_i;
  assign accept = start_i && (state == IDLE || state == DONE);
  assign busy_o = (state == CALC) || (state == FIX);
  assign done_o = (state == DONE);
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    div_p    = {acc[63:32], acc[31]};
    div_ge   = div_p >= {1'b0, m};
    div_r    = div_p[31:0] - m;
    acc_step = is_div ? (div_ge ? {div_r, acc[30:0], 1'b1} : {div_p[31:0], acc[30:0], 1'b0})
                      : {mul_sum, acc[31:1]};
    prod     = sign_q ? -acc : acc;
    quo      = sign_q ? -acc[31:0] : acc[31:0];
    rem      = sign_n ? -acc[63:32] : acc[63:32];
    hi_fix   = !is_div ? prod[63:32] : (m == '0 ? rs : rem);
    lo_fix   = !is_div ? prod[31:0] : (m == '0 ? '1 : quo);
  end
  always_comb begin
    state_n = (state == CALC) ? (cnt == 5'd31 ? FIX : CALC) :
              (state == FIX)  ? DONE :
              (start_i ? CALC : IDLE);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_div <= 1'b0;
      sign_n <= 1'b0;
      sign_q <= 1'b0;
      m      <= '0;
      rs     <= '0;
      acc    <= '0;
      cnt    <= '0;
      HI_o   <= '0;
      LO_o   <= '0;
    end else if (accept) begin
      is_div <= op_i[1];
      sign_n <= sgn && RS_data_i[31];
      sign_q <= sgn && (RS_data_i[31] ^ RT_data_i[31]);
      m      <= op_i[1] ? rt_mag : rs_mag;
      rs     <= RS_data_i;
      acc    <= {32'd0, op_i[1] ? rs_mag : rt_mag};
      cnt    <= '0;
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
    end else if (state == FIX) begin
      HI_o <= hi_fix;
      LO_o <= lo_fix;
    end
  end
endmodule
